// File: rtl/spi_arb_pkg.sv
// ---------------------------------------------------------------------------
// spi_arb_pkg
// Shared definitions for the SPI transaction arbiter:
//   - state_t    : arbiter FSM states
//   - LEN_*      : transfer length codes carried on req_len / m_len
//   - RETRY_LIMIT, BUSY_WAIT_LIMIT : start re-strobe policy
// ---------------------------------------------------------------------------
package spi_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_RUN       = 3'd4,
        ST_SETTLE    = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

    localparam logic [1:0] LEN_8  = 2'd0;
    localparam logic [1:0] LEN_16 = 2'd1;
    localparam logic [1:0] LEN_24 = 2'd2;
    localparam logic [1:0] LEN_32 = 2'd3;

    // Number of re-strobes after the first m_start before giving up.
    localparam int RETRY_LIMIT     = 3;
    // Consecutive idle-busy cycles tolerated after each m_start.
    localparam int BUSY_WAIT_LIMIT = 4;

endpackage

// File: rtl/spi_txn_arbiter_if.sv
// ---------------------------------------------------------------------------
// spi_txn_arbiter_if
// Bundles the client request bus and the SPI master control bus.
//   modport master : the arbiter (drives grant/done/error/rx_data and m_*)
//   modport slave  : the environment (clients + SPI master)
// Client side : req, req_tx_data, req_chip_addr, req_len, req_div, req_mode,
//               grant, done, error, rx_data
// Master side : m_start, m_busy, m_rx_data, m_tx_data, m_chip_addr, m_len,
//               m_div, m_cpol, m_cpha
// ---------------------------------------------------------------------------
interface spi_txn_arbiter_if #(
    parameter int REQ_COUNT       = 4,
    parameter int SLAVE_ADDRS_LEN = 3
);
    logic [REQ_COUNT-1:0]                 req;
    logic [32*REQ_COUNT-1:0]              req_tx_data;
    logic [SLAVE_ADDRS_LEN*REQ_COUNT-1:0] req_chip_addr;
    logic [2*REQ_COUNT-1:0]               req_len;
    logic [4*REQ_COUNT-1:0]               req_div;
    logic [2*REQ_COUNT-1:0]               req_mode;
    logic [REQ_COUNT-1:0]                 grant;
    logic [REQ_COUNT-1:0]                 done;
    logic                                 error;
    logic [31:0]                          rx_data;

    logic                                 m_start;
    logic                                 m_busy;
    logic [31:0]                          m_rx_data;
    logic [31:0]                          m_tx_data;
    logic [SLAVE_ADDRS_LEN-1:0]           m_chip_addr;
    logic [1:0]                           m_len;
    logic [3:0]                           m_div;
    logic                                 m_cpol;
    logic                                 m_cpha;

    modport master (
        input  req, req_tx_data, req_chip_addr, req_len, req_div, req_mode,
        input  m_busy, m_rx_data,
        output grant, done, error, rx_data,
        output m_start, m_tx_data, m_chip_addr, m_len, m_div, m_cpol, m_cpha
    );

    modport slave (
        output req, req_tx_data, req_chip_addr, req_len, req_div, req_mode,
        output m_busy, m_rx_data,
        input  grant, done, error, rx_data,
        input  m_start, m_tx_data, m_chip_addr, m_len, m_div, m_cpol, m_cpha
    );
endinterface

// File: rtl/spi_rr_picker.sv
// ---------------------------------------------------------------------------
// spi_rr_picker
// Combinational round-robin selector: returns the first set bit of i_req at
// or after i_ptr, wrapping past REQ_COUNT-1 back to 0.
//   i_req   : request vector
//   i_ptr   : index with highest priority this round
//   o_idx   : winning index (valid only when o_valid)
//   o_valid : at least one request is set
// ---------------------------------------------------------------------------
module spi_rr_picker #(
    parameter int REQ_COUNT = 4
) (
    input  logic [REQ_COUNT-1:0]         i_req,
    input  logic [$clog2(REQ_COUNT)-1:0] i_ptr,
    output logic [$clog2(REQ_COUNT)-1:0] o_idx,
    output logic                         o_valid
);
    localparam int IDX_W = $clog2(REQ_COUNT);

    int w_pos;

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // it unassigned, which would otherwise infer a latch.
        o_idx   = '0;
        o_valid = 1'b0;
        w_pos   = 0;
        // Scan from farthest to nearest; the last hit written is the nearest
        // one to the pointer, which is the round-robin winner.
        for (int k = REQ_COUNT - 1; k >= 0; k--) begin
            w_pos = int'(i_ptr) + k;
            if (w_pos >= REQ_COUNT) w_pos = w_pos - REQ_COUNT;
            if (i_req[w_pos]) begin
                o_idx   = IDX_W'(w_pos);
                o_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/spi_txn_arbiter.sv
// ---------------------------------------------------------------------------
// spi_txn_arbiter
// Shares one SPI master between REQ_COUNT requesters using round-robin
// arbitration. The winner's config is registered onto the master bus one
// cycle ahead of a single-cycle m_start; the master's busy is tracked and
// the received word is returned with a one-cycle done pulse to the owner.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : spi_txn_arbiter_if.master (client and SPI master signals)
// Optional feature macro: SPI_ARB_WATCHDOG_EN
//   defined   : RUN is bounded by TIMEOUT_CYCLES; timeout aborts with error
//               and rx_data=0; arbitration waits for m_busy=0 in IDLE.
//   undefined : RUN waits for m_busy to fall indefinitely.
// ---------------------------------------------------------------------------
module spi_txn_arbiter
    import spi_arb_pkg::*;
#(
    parameter int REQ_COUNT       = 4,
    parameter int SLAVE_ADDRS_LEN = 3,
    parameter int TIMEOUT_CYCLES  = 65535
) (
    input  logic              clk,
    input  logic              rst,
    spi_txn_arbiter_if.master bus
);
    localparam int IDX_W = $clog2(REQ_COUNT);

    state_t                     r_state;
    logic [IDX_W-1:0]           r_ptr;
    logic [IDX_W-1:0]           r_owner;
    logic [1:0]                 r_wait;
    logic [1:0]                 r_retry;
    logic [REQ_COUNT-1:0]       r_grant;
    logic [REQ_COUNT-1:0]       r_done;
    logic                       r_error;
    logic                       r_start;
    logic [31:0]                r_rx_data;
    logic [31:0]                r_m_tx_data;
    logic [SLAVE_ADDRS_LEN-1:0] r_m_chip_addr;
    logic [1:0]                 r_m_len;
    logic [3:0]                 r_m_div;
    logic                       r_m_cpol;
    logic                       r_m_cpha;
`ifdef SPI_ARB_WATCHDOG_EN
    logic [15:0]                r_wd;
`endif

    logic [IDX_W-1:0]           w_pick_idx;
    logic                       w_pick_valid;
    logic                       w_arb_ok;
    logic [REQ_COUNT-1:0]       w_owner_oh;

    logic [31:0]                w_tx   [REQ_COUNT];
    logic [SLAVE_ADDRS_LEN-1:0] w_addr [REQ_COUNT];
    logic [1:0]                 w_len  [REQ_COUNT];
    logic [3:0]                 w_div  [REQ_COUNT];
    logic [1:0]                 w_mode [REQ_COUNT];

    for (genvar g = 0; g < REQ_COUNT; g++) begin : g_unpack
        assign w_tx[g]   = bus.req_tx_data[32*g +: 32];
        assign w_addr[g] = bus.req_chip_addr[SLAVE_ADDRS_LEN*g +: SLAVE_ADDRS_LEN];
        assign w_len[g]  = bus.req_len[2*g +: 2];
        assign w_div[g]  = bus.req_div[4*g +: 4];
        assign w_mode[g] = bus.req_mode[2*g +: 2];
    end

    spi_rr_picker #(.REQ_COUNT(REQ_COUNT)) u_picker (
        .i_req   (bus.req),
        .i_ptr   (r_ptr),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

`ifdef SPI_ARB_WATCHDOG_EN
    // After a timeout the master may still be running; hold off a new start.
    assign w_arb_ok = w_pick_valid & ~bus.m_busy;
`else
    assign w_arb_ok = w_pick_valid;
`endif

    assign w_owner_oh = REQ_COUNT'(1) << r_owner;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_ptr         <= '0;
            r_owner       <= '0;
            r_wait        <= '0;
            r_retry       <= '0;
            r_grant       <= '0;
            r_done        <= '0;
            r_error       <= 1'b0;
            r_start       <= 1'b0;
            r_rx_data     <= '0;
            r_m_tx_data   <= '0;
            r_m_chip_addr <= '0;
            r_m_len       <= '0;
            r_m_div       <= '0;
            r_m_cpol      <= 1'b0;
            r_m_cpha      <= 1'b0;
`ifdef SPI_ARB_WATCHDOG_EN
            r_wd          <= '0;
`endif
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples pre-edge values; the strobes below default low
            // and are raised for a single cycle by the states that need them.
            r_start <= 1'b0;
            r_done  <= '0;
            r_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_ok) begin
                        r_owner <= w_pick_idx;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_grant       <= w_owner_oh;
                    r_m_tx_data   <= w_tx[r_owner];
                    r_m_chip_addr <= w_addr[r_owner];
                    r_m_len       <= w_len[r_owner];
                    r_m_div       <= w_div[r_owner];
                    r_m_cpol      <= w_mode[r_owner][1];
                    r_m_cpha      <= w_mode[r_owner][0];
                    r_retry       <= '0;
                    r_state       <= ST_START;
                end
                ST_START: begin
                    r_start <= 1'b1;
                    r_wait  <= '0;
                    r_state <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (bus.m_busy) begin
`ifdef SPI_ARB_WATCHDOG_EN
                        r_wd    <= '0;
`endif
                        r_state <= ST_RUN;
                    end else if (r_wait == 2'(BUSY_WAIT_LIMIT - 1)) begin
                        if (r_retry == 2'(RETRY_LIMIT)) begin
                            // Master never acknowledged: abort with error.
                            r_done    <= w_owner_oh;
                            r_error   <= 1'b1;
                            r_rx_data <= '0;
                            r_state   <= ST_DONE;
                        end else begin
                            r_retry <= r_retry + 1'b1;
                            r_state <= ST_START;
                        end
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                ST_RUN: begin
`ifdef SPI_ARB_WATCHDOG_EN
                    if (!bus.m_busy) begin
                        r_state <= ST_SETTLE;
                    end else if (r_wd == 16'(TIMEOUT_CYCLES - 1)) begin
                        r_done    <= w_owner_oh;
                        r_error   <= 1'b1;
                        r_rx_data <= '0;
                        r_state   <= ST_DONE;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
`else
                    if (!bus.m_busy) r_state <= ST_SETTLE;
`endif
                end
                ST_SETTLE: begin
                    // done/rx_data are registered on entry so they are valid
                    // during the DONE cycle while grant is still held.
                    r_done    <= w_owner_oh;
                    r_rx_data <= bus.m_rx_data;
                    r_state   <= ST_DONE;
                end
                ST_DONE: begin
                    r_grant <= '0;
                    r_ptr   <= (r_owner == IDX_W'(REQ_COUNT - 1)) ? '0 : r_owner + 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.grant       = r_grant;
    assign bus.done        = r_done;
    assign bus.error       = r_error;
    assign bus.rx_data     = r_rx_data;
    assign bus.m_start     = r_start;
    assign bus.m_tx_data   = r_m_tx_data;
    assign bus.m_chip_addr = r_m_chip_addr;
    assign bus.m_len       = r_m_len;
    assign bus.m_div       = r_m_div;
    assign bus.m_cpol      = r_m_cpol;
    assign bus.m_cpha      = r_m_cpha;
endmodule

// File: tb/tb_spi_txn_arbiter.sv
// ---------------------------------------------------------------------------
// tb_spi_txn_arbiter
// Self-checking bench for spi_txn_arbiter (REQ_COUNT=4, SLAVE_ADDRS_LEN=3,
// TIMEOUT_CYCLES=100). Includes a small SPI master model that raises busy
// after each m_start and posts a receive word when busy falls.
// ---------------------------------------------------------------------------
module tb_spi_txn_arbiter;
    import spi_arb_pkg::*;

    localparam int N = 4;

    logic clk;
    logic rst;

    spi_txn_arbiter_if #(.REQ_COUNT(N), .SLAVE_ADDRS_LEN(3)) bus ();

    spi_txn_arbiter #(
        .REQ_COUNT       (N),
        .SLAVE_ADDRS_LEN (3),
        .TIMEOUT_CYCLES  (100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- SPI master model ----------------
    int          busy_len   = 3;
    bit          no_busy    = 1'b0;
    bit          stuck_busy = 1'b0;
    logic [31:0] rx_word    = 32'h0;
    int          m_cnt      = 0;

    initial begin
        bus.m_busy    = 1'b0;
        bus.m_rx_data = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_cnt      = 0;
                bus.m_busy = 1'b0;
            end else if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    if (!stuck_busy) bus.m_busy = 1'b0;
                    bus.m_rx_data = rx_word;
                end
            end else if (bus.m_busy && !stuck_busy) begin
                bus.m_busy = 1'b0;
            end else if (bus.m_start && !no_busy) begin
                bus.m_busy = 1'b1;
                m_cnt      = busy_len;
            end
        end
    end

    // ---------------- requester fields ----------------
    logic [31:0] f_tx   [N];
    logic [2:0]  f_addr [N];
    logic [1:0]  f_len  [N];
    logic [3:0]  f_div  [N];
    logic [1:0]  f_mode [N];

    task automatic drive_fields();
        for (int i = 0; i < N; i++) begin
            bus.req_tx_data[32*i +: 32]  = f_tx[i];
            bus.req_chip_addr[3*i +: 3]  = f_addr[i];
            bus.req_len[2*i +: 2]        = f_len[i];
            bus.req_div[4*i +: 4]        = f_div[i];
            bus.req_mode[2*i +: 2]       = f_mode[i];
        end
    endtask

    // Requester `base` gets exactly the given values; the others get
    // distinct variants so a wrong selection shows up in the config.
    task automatic set_fields(input int base, input logic [31:0] tx, input logic [2:0] addr,
                              input logic [1:0] len, input logic [3:0] div, input logic [1:0] mode);
        for (int i = 0; i < N; i++) begin
            int d;
            d = (i + N - base) % N;
            f_tx[i]   = tx ^ (32'(d) * 32'h0101_0101);
            f_addr[i] = 3'(int'(addr) + d);
            f_len[i]  = len ^ 2'(d);
            f_div[i]  = 4'(int'(div) + d);
            f_mode[i] = mode ^ 2'(d);
        end
        drive_fields();
    endtask

    task automatic rand_fields();
        for (int i = 0; i < N; i++) begin
            f_tx[i]   = $urandom;
            f_addr[i] = 3'($urandom_range(0, 7));
            f_len[i]  = 2'($urandom_range(0, 3));
            f_div[i]  = 4'($urandom_range(0, 15));
            f_mode[i] = 2'($urandom_range(0, 3));
        end
        drive_fields();
    endtask

    // Reference arbitration rule: first requester at or after ptr, wrapping.
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst     = 1'b1;
        bus.req = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits for m_start; lat = negedges from call until the strobe is seen.
    task automatic expect_start(input int exp_idx, input string tag, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        for (int c = 1; c <= 200 && !seen; c++) begin
            @(negedge clk);
            if (bus.m_start) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        check({tag, " start_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, " grant"},     32'(bus.grant),       32'(4'b0001 << exp_idx));
            check({tag, " m_tx_data"}, bus.m_tx_data,        f_tx[exp_idx]);
            check({tag, " m_addr"},    32'(bus.m_chip_addr), 32'(f_addr[exp_idx]));
            check({tag, " m_len"},     32'(bus.m_len),       32'(f_len[exp_idx]));
            check({tag, " m_div"},     32'(bus.m_div),       32'(f_div[exp_idx]));
            check({tag, " m_mode"},    32'({bus.m_cpol, bus.m_cpha}), 32'(f_mode[exp_idx]));
        end
    endtask

    task automatic expect_done(input int exp_idx, input string tag);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clk);
            if (bus.done != '0) seen = 1'b1;
        end
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, " done"},    32'(bus.done),  32'(4'b0001 << exp_idx));
            check({tag, " error"},   32'(bus.error), 32'd0);
            check({tag, " rx_data"}, bus.rx_data,    rx_word);
        end
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic [31:0]  tx;
        logic [2:0]   addr;
        logic [1:0]   len;
        logic [3:0]   div;
        logic [1:0]   mode;
        logic [31:0]  rx;
        int           exp_idx;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int lat;
        int ptr_m;
        int exp_i;
        int starts;
        bit got;
        logic [N-1:0] nreq;

        // Expected winners follow from the pointer starting at 0 after reset
        // and moving to owner+1 after each completion.
        vecs[0] = '{4'b0010, 32'hA5A5_0000, 3'd2, LEN_8,  4'd3, 2'b00, 32'h1234_5678, 1};
        vecs[1] = '{4'b1111, 32'h0BAD_F00D, 3'd5, LEN_16, 4'd7, 2'b01, 32'hCAFE_0001, 2};
        vecs[2] = '{4'b0001, 32'hDEAD_BEEF, 3'd0, LEN_24, 4'd1, 2'b10, 32'h0000_00FF, 0};
        vecs[3] = '{4'b1001, 32'h1357_9BDF, 3'd7, LEN_32, 4'd9, 2'b11, 32'hFFFF_0000, 3};
        vecs[4] = '{4'b0110, 32'h2468_ACE0, 3'd4, LEN_16, 4'd0, 2'b10, 32'h8000_0001, 1};
        vecs[5] = '{4'b0011, 32'h0F0F_0F0F, 3'd1, LEN_8,  4'd15, 2'b01, 32'h5555_AAAA, 0};

        bus.req = '0;
        set_fields(0, 32'h0, 3'd0, LEN_8, 4'd0, 2'b00);
        do_reset();

        // ---- reset values ----
        check("rst grant",     32'(bus.grant),       32'd0);
        check("rst done",      32'(bus.done),        32'd0);
        check("rst error",     32'(bus.error),       32'd0);
        check("rst rx_data",   bus.rx_data,          32'd0);
        check("rst m_start",   32'(bus.m_start),     32'd0);
        check("rst m_tx_data", bus.m_tx_data,        32'd0);
        check("rst m_addr",    32'(bus.m_chip_addr), 32'd0);
        check("rst m_len",     32'(bus.m_len),       32'd0);
        check("rst m_div",     32'(bus.m_div),       32'd0);
        check("rst m_cpol",    32'(bus.m_cpol),      32'd0);
        check("rst m_cpha",    32'(bus.m_cpha),      32'd0);

        // ---- table-driven transactions ----
        for (int v = 0; v < 6; v++) begin
            set_fields(vecs[v].exp_idx, vecs[v].tx, vecs[v].addr, vecs[v].len, vecs[v].div, vecs[v].mode);
            bus.req  = vecs[v].req;
            rx_word  = vecs[v].rx;
            busy_len = 2 + v;
            expect_start(vecs[v].exp_idx, $sformatf("vec%0d", v), lat);
            if (v == 0) check("vec0 req_to_start_latency", 32'(lat), 32'd3);
            expect_done(vecs[v].exp_idx, $sformatf("vec%0d", v));
        end
        bus.req = '0;

        // ---- all four requesting for 8 transactions ----
        do_reset();
        set_fields(0, 32'h7000_0000, 3'd3, LEN_32, 4'd5, 2'b01);
        bus.req  = 4'b1111;
        busy_len = 3;
        for (int k = 0; k < 8; k++) begin
            rx_word = 32'hABC0_0000 + 32'(k);
            expect_start(k % N, $sformatf("rr%0d", k), lat);
            if (k == 0) check("rr0 latency", 32'(lat), 32'd3);
            else        check($sformatf("rr%0d done_to_start>=4", k), 32'(lat >= 4), 32'd1);
            expect_done(k % N, $sformatf("rr%0d", k));
        end
        bus.req = '0;

        // ---- req[2] dropped while running ----
        do_reset();
        set_fields(2, 32'h2222_2222, 3'd6, LEN_24, 4'd2, 2'b11);
        bus.req  = 4'b0100;
        busy_len = 6;
        rx_word  = 32'h600D_0002;
        expect_start(2, "drop", lat);
        repeat (2) @(negedge clk);
        bus.req = 4'b1001;
        expect_done(2, "drop");
        rx_word = 32'h600D_0003;
        expect_start(3, "drop_next", lat);
        expect_done(3, "drop_next");
        rx_word = 32'h600D_0000;
        expect_start(0, "drop_next2", lat);
        expect_done(0, "drop_next2");
        bus.req = '0;

        // ---- master never raises busy: 4 strobes then error ----
        do_reset();
        no_busy = 1'b1;
        bus.req = 4'b0001;
        starts  = 0;
        got     = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if (bus.m_start) starts++;
            if (bus.done != '0) got = 1'b1;
        end
        check("nobusy done_seen", 32'(got),       32'd1);
        check("nobusy starts",    32'(starts),    32'd4);
        check("nobusy done",      32'(bus.done),  32'd1);
        check("nobusy error",     32'(bus.error), 32'd1);
        bus.req = '0;
        no_busy = 1'b0;
        @(negedge clk);
        check("nobusy error_pulse", 32'(bus.error), 32'd0);

        // ---- asynchronous reset during RUN ----
        do_reset();
        set_fields(2, 32'h3333_0000, 3'd1, LEN_16, 4'd4, 2'b10);
        bus.req  = 4'b0100;
        busy_len = 20;
        expect_start(2, "arst", lat);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst grant",     32'(bus.grant),   32'd0);
        check("arst m_start",   32'(bus.m_start), 32'd0);
        check("arst m_tx_data", bus.m_tx_data,    32'd0);
        bus.req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        set_fields(1, 32'h4444_0001, 3'd3, LEN_8, 4'd6, 2'b01);
        bus.req  = 4'b0010;
        busy_len = 3;
        rx_word  = 32'h0A5A_5A5A;
        expect_start(1, "arst_after", lat);
        check("arst_after latency", 32'(lat), 32'd3);
        expect_done(1, "arst_after");
        bus.req = '0;

`ifdef SPI_ARB_WATCHDOG_EN
        // ---- busy stuck high: watchdog abort ----
        do_reset();
        stuck_busy = 1'b1;
        busy_len   = 1;
        bus.req    = 4'b0001;
        expect_start(0, "wd", lat);
        got = 1'b0;
        starts = 0;
        for (int c = 1; c <= 300 && !got; c++) begin
            @(negedge clk);
            if (bus.done != '0) begin
                got    = 1'b1;
                starts = c;
            end
        end
        check("wd done_seen", 32'(got),        32'd1);
        check("wd cycles",    32'(starts >= 99 && starts <= 102), 32'd1);
        check("wd error",     32'(bus.error),  32'd1);
        check("wd rx_data",   bus.rx_data,     32'd0);
        bus.req    = '0;
        stuck_busy = 1'b0;
        repeat (3) @(negedge clk);
`endif

        // ---- randomized traffic against the reference model ----
        do_reset();
        ptr_m = 0;
        rand_fields();
        bus.req = 4'($urandom_range(1, 15));
        for (int t = 0; t < 30; t++) begin
            exp_i    = pick(bus.req, ptr_m);
            busy_len = $urandom_range(1, 5);
            rx_word  = $urandom;
            expect_start(exp_i, $sformatf("rnd%0d", t), lat);
            expect_done(exp_i, $sformatf("rnd%0d", t));
            ptr_m = (exp_i + 1) % N;
            // Waiting requesters keep their request; the owner may drop or
            // re-request, and new requesters may join.
            nreq = bus.req | 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) nreq[exp_i] = 1'b0;
            if (nreq == '0) nreq[$urandom_range(0, N - 1)] = 1'b1;
            bus.req = nreq;
            rand_fields();
            @(negedge clk);
            check($sformatf("rnd%0d done_pulse_width", t), 32'(bus.done), 32'd0);
        end
        bus.req = '0;
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit reached");
    end
endmodule
